// File: rtl/sha1_block_loader.sv
`default_nettype none
// ============================================================================
//  Module   : sha1_block_loader
//  Brief    : Packs a 32-bit message stream big-endian into 512-bit blocks,
//             buffers them in a small FIFO and sequences the sha1 core.
//             Optional build macro: SHA1_LOADER_UNDERRUN_EN (underrun flag).
//  Revision : 1.0 - initial release
// ============================================================================
module sha1_block_loader #(
    parameter int DEPTH = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  s_data,
    input  logic [2:0]   s_nbytes,
    input  logic         s_last,
    input  logic         s_valid,
    output logic         s_ready,
    output logic         start,
    output logic         eof,
    output logic [511:0] data_block,
    output logic [63:0]  msg_length,
    input  logic         next_block,
    input  logic         done,
    output logic         busy,
    output logic         underrun
);

    localparam int              PW         = (DEPTH > 2) ? 2 : 1;
    localparam logic [PW-1:0]   c_PTR_LAST = PW'(DEPTH - 1);
    localparam logic [2:0]      c_DEPTH    = 3'(DEPTH);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FILL   = 3'd1;
    localparam logic [2:0] c_LAUNCH = 3'd2;
    localparam logic [2:0] c_STREAM = 3'd3;
    localparam logic [2:0] c_DRAIN  = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [511:0]  r_fifo [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [2:0]    r_count;
    logic [2:0]    w_count_nxt;
    logic [511:0]  r_cur;
    logic [511:0]  w_cur_nxt;
    logic [3:0]    r_idx;
    logic [63:0]   r_len;
    logic          r_ended;
    logic          r_start;
    logic          r_busy;
    logic [31:0]   w_word;
    logic          w_active;
    logic          w_free;
    logic          w_accept;
    logic          w_commit;
    logic          w_pop;
    logic          w_clear;
    logic          w_ended_nxt;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_active = (r_state == c_IDLE) || (r_state == c_FILL) || (r_state == c_STREAM);
    assign w_free   = (r_count != c_DEPTH);
    // A final beat always commits its partial block, so it needs a free entry too.
    assign s_ready  = w_active && !r_ended && (w_free || ((r_idx != 4'd15) && !s_last));

    assign w_accept    = s_valid && s_ready;
    assign w_commit    = w_accept && ((r_idx == 4'd15) ||
                                      (s_last && ((r_idx != 4'd0) || (s_nbytes != 3'd0))));
    assign w_pop       = next_block && (r_count != 3'd0);
    assign w_clear     = (r_state == c_DRAIN) && done;
    assign w_ended_nxt = r_ended || (w_accept && s_last);

    always_comb begin
        w_word = s_data;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) >= s_nbytes) begin
                w_word[8*(3-b) +: 8] = 8'h00;
            end
        end
        w_cur_nxt = r_cur;
        // Word 0 occupies the most significant 32 bits of the block.
        w_cur_nxt[{~r_idx, 5'b0} +: 32] = w_word;
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_commit && !w_pop) begin
            w_count_nxt = r_count + 3'd1;
        end else if (!w_commit && w_pop) begin
            w_count_nxt = r_count - 3'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_accept) w_state_nxt = s_last ? c_LAUNCH : c_FILL;
            c_FILL:   if ((w_count_nxt >= 3'd2) || w_ended_nxt) w_state_nxt = c_LAUNCH;
            c_LAUNCH: w_state_nxt = r_ended ? c_DRAIN : c_STREAM;
            c_STREAM: if (w_ended_nxt) w_state_nxt = c_DRAIN;
            c_DRAIN:  if (done) w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= (w_state_nxt == c_LAUNCH);
            r_busy  <= (w_state_nxt != c_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= 3'd0;
            r_idx   <= 4'd0;
            r_cur   <= '0;
            r_len   <= 64'd0;
            r_ended <= 1'b0;
        end else begin
            if (w_accept) begin
                r_len <= r_len + 64'(s_nbytes);
                r_idx <= w_commit ? 4'd0 : r_idx + 4'd1;
                r_cur <= w_commit ? '0 : w_cur_nxt;
            end
            if (w_commit) begin
                r_wr <= f_inc(r_wr);
            end
            if (w_pop) begin
                r_rd <= f_inc(r_rd);
            end
            r_count <= w_count_nxt;
            r_ended <= w_ended_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_fifo[r_wr] <= w_cur_nxt;
        end
    end

    assign start      = r_start;
    assign busy       = r_busy;
    assign msg_length = r_len;
    assign eof        = r_ended && (r_count == 3'd0);
    assign data_block = (r_count != 3'd0) ? r_fifo[r_rd] : '0;

`ifdef SHA1_LOADER_UNDERRUN_EN
    logic r_underrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_underrun <= 1'b0;
        end else if (next_block && (r_count == 3'd0) && !r_ended) begin
            r_underrun <= 1'b1;
        end
    end

    assign underrun = r_underrun;
`else
    assign underrun = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha1_block_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha1_block_loader
//  Brief    : Self-checking bench: random messages, byte-level block model,
//             simple core model popping blocks at a fixed interval.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sha1_block_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  s_data = '0;
    logic [2:0]   s_nbytes = '0;
    logic         s_last = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic         start;
    logic         eof;
    logic [511:0] data_block;
    logic [63:0]  msg_length;
    logic         next_block = 1'b0;
    logic         done = 1'b0;
    logic         busy;
    logic         underrun;

`ifdef SHA1_LOADER_UNDERRUN_EN
    localparam logic c_UR_EXP = 1'b1;
`else
    localparam logic c_UR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    sha1_block_loader #(.DEPTH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_nbytes   (s_nbytes),
        .s_last     (s_last),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .start      (start),
        .eof        (eof),
        .data_block (data_block),
        .msg_length (msg_length),
        .next_block (next_block),
        .done       (done),
        .busy       (busy),
        .underrun   (underrun)
    );

    int           n_pass  = 0;
    int           n_total = 0;
    logic         saw_stall;
    logic [7:0]   msg     [0:511];
    logic [511:0] exp_blk [0:7];

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    endtask

    task automatic chk_w(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: message bytes laid out in order, 64 per block, zero padded.
    task automatic calc_exp(input int len);
        for (int b = 0; b < 8; b++) begin
            exp_blk[b] = '0;
            for (int k = 0; k < 64; k++) begin
                if (64*b + k < len) exp_blk[b][511-8*k -: 8] = msg[64*b + k];
            end
        end
    endtask

    task automatic rand_msg(input int len);
        for (int i = 0; i < 512; i++) msg[i] = 8'($urandom);
        calc_exp(len);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [2:0] nb, input logic last);
        int   w;
        logic acc;
        w   = 0;
        acc = 1'b0;
        s_valid  = 1'b1;
        s_data   = d;
        s_nbytes = nb;
        s_last   = last;
        while (!acc && w < 2000) begin
            #1;
            acc = s_ready;
            if (!acc) saw_stall = 1'b1;
            @(negedge clk);
            w++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk_b("beat_accept", acc, 1'b1);
    endtask

    task automatic send_msg(input int len, input bit gaps, input bit with_last);
        int nb;
        nb = (len == 0) ? 1 : (len + 3) / 4;
        for (int i = 0; i < nb; i++) begin
            logic [31:0] d;
            int          cnt;
            cnt = (i == nb - 1) ? len - 4*i : 4;
            d   = $urandom;
            for (int k = 0; k < cnt; k++) d[31-8*k -: 8] = msg[4*i + k];
            if (gaps && $urandom_range(0, 7) == 0) @(negedge clk);
            send_beat(d, 3'(cnt), with_last && (i == nb - 1));
        end
    endtask

    task automatic run_core(input int nblk, input int npop, input int gap, input logic ended);
        int w;
        w = 0;
        while (start !== 1'b1 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk_b("start_seen", start, 1'b1);
        for (int i = 0; i < npop; i++) begin
            if (i > 0) repeat (gap) @(negedge clk);
            chk_w($sformatf("blk%0d", i), data_block, (i < nblk) ? exp_blk[i] : 512'd0);
            next_block = 1'b1;
            @(negedge clk);
            next_block = 1'b0;
            if (i == 0) begin
                saw_stall = 1'b0;
                chk_b("start_one_cycle", start, 1'b0);
                if (nblk > 1) chk_w("blk1_ready", data_block, exp_blk[1]);
                else if (ended) chk_b("eof_after_pop0", eof, 1'b1);
            end
        end
        if (ended) chk_b("eof_end", eof, 1'b1);
    endtask

    task automatic finish_msg(input logic [63:0] len);
        chk_w("msg_length", 512'(msg_length), 512'(len));
        chk_b("drain_busy", busy, 1'b1);
        chk_b("drain_ready", s_ready, 1'b0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk_b("idle_ready", s_ready, 1'b1);
        chk_b("idle_busy", busy, 1'b0);
        chk_w("len_cleared", 512'(msg_length), 512'd0);
    endtask

    task automatic check_reset(input string tag);
        chk_b({tag, "_ready"}, s_ready, 1'b1);
        chk_b({tag, "_start"}, start, 1'b0);
        chk_b({tag, "_eof"}, eof, 1'b0);
        chk_w({tag, "_block"}, data_block, 512'd0);
        chk_w({tag, "_len"}, 512'(msg_length), 512'd0);
        chk_b({tag, "_busy"}, busy, 1'b0);
        chk_b({tag, "_underrun"}, underrun, 1'b0);
    endtask

    task automatic abc_test();
        rand_msg(0);
        msg[0] = 8'h61;
        msg[1] = 8'h62;
        msg[2] = 8'h63;
        calc_exp(3);
        send_beat(32'h6162_6300, 3'd3, 1'b1);
        chk_b("abc_start", start, 1'b1);
        chk_w("abc_block", data_block, {24'h616263, 488'd0});
        run_core(1, 1, 0, 1'b1);
        finish_msg(64'd3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        saw_stall = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        abc_test();

        // zero-length message
        rand_msg(0);
        send_msg(0, 1'b0, 1'b1);
        chk_b("zl_start", start, 1'b1);
        chk_b("zl_ready", s_ready, 1'b0);
        run_core(0, 1, 0, 1'b1);
        finish_msg(64'd0);

        // exact 64 and 128 bytes
        rand_msg(64);
        fork
            send_msg(64, 1'b1, 1'b1);
            run_core(1, 1, 85, 1'b1);
        join
        finish_msg(64'd64);

        rand_msg(128);
        fork
            send_msg(128, 1'b1, 1'b1);
            run_core(2, 2, 85, 1'b1);
        join
        finish_msg(64'd128);

        // 300-byte stream with backpressure from a full FIFO
        rand_msg(300);
        fork
            send_msg(300, 1'b1, 1'b1);
            run_core(5, 5, 85, 1'b1);
        join
        chk_b("stall_seen", saw_stall, 1'b1);
        finish_msg(64'd300);

        // upstream stalls after two blocks while the core keeps popping
        rand_msg(128);
        send_msg(128, 1'b0, 1'b0);
        run_core(2, 3, 85, 1'b0);
        chk_b("underrun", underrun, c_UR_EXP);
        repeat (5) @(negedge clk);
        chk_b("underrun_sticky", underrun, c_UR_EXP);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("rst_after_underrun");

        // reset in the middle of streaming
        rand_msg(160);
        send_msg(160, 1'b0, 1'b0);
        chk_b("stream_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("midrst");
        abc_test();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
